// File: rtl/vend_pkg.sv
// vend_pkg: shared definitions for the vending controller.
//   - FSM state encoding (exported on the debug state bus)
//   - coin values in quarters
//   - credit width and helper types
package vend_pkg;

    localparam int CREDIT_W = 4;

    typedef logic [CREDIT_W-1:0] credit_t;
    // One extra bit so that credit + coin can be compared without wrapping.
    typedef logic [CREDIT_W:0]   credit_x_t;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_CREDIT   = 2'd1;
    localparam logic [1:0] ST_DISPENSE = 2'd2;
    localparam logic [1:0] ST_CHANGE   = 2'd3;

    localparam credit_t QUARTER = credit_t'(1);
    localparam credit_t DOLLAR  = credit_t'(4);

    localparam logic ITEM_A = 1'b0;
    localparam logic ITEM_B = 1'b1;

    // True when adding coin value 'val' to 'cur' stays within the ceiling.
    function automatic logic coin_fits(input credit_t cur, input credit_t val,
                                       input int unsigned max_credit);
        return (credit_x_t'(cur) + credit_x_t'(val)) <= credit_x_t'(max_credit);
    endfunction

endpackage

// File: rtl/vend_if.sv
// vend_if: front-panel / mechanism bus of the vending controller.
//   Inputs to the controller: q_in, d_in, sel_a, sel_b, cancel (one-cycle
//   pulses), disp_ack, chg_ack (acknowledges).
//   Outputs from the controller: disp_req, disp_item, chg_req, coin_rej,
//   credit, busy, plus the debug state bus.
//   master : the machine side (coin mech, buttons, dispenser, changer).
//   slave  : the controller.
//
// Handshakes: disp_req/disp_ack and chg_req/chg_ack are req/ack pairs.
// The controller raises req as a level and holds it (with disp_item stable)
// until it samples ack=1 on a rising edge; that edge completes exactly one
// transfer. ack is only meaningful while the matching req is 1 and is
// ignored otherwise. A chg_req transfer ejects one quarter; chg_req stays
// high across back-to-back transfers until the credit is exhausted.
interface vend_if;
    import vend_pkg::*;

    logic       q_in;
    logic       d_in;
    logic       sel_a;
    logic       sel_b;
    logic       cancel;
    logic       disp_ack;
    logic       chg_ack;

    logic       disp_req;
    logic       disp_item;
    logic       chg_req;
    logic       coin_rej;
    credit_t    credit;
    logic       busy;
    logic [1:0] state;

    modport master (
        output q_in, d_in, sel_a, sel_b, cancel, disp_ack, chg_ack,
        input  disp_req, disp_item, chg_req, coin_rej, credit, busy, state
    );

    modport slave (
        input  q_in, d_in, sel_a, sel_b, cancel, disp_ack, chg_ack,
        output disp_req, disp_item, chg_req, coin_rej, credit, busy, state
    );

endinterface

// File: rtl/vend_timer.sv
// vend_timer: idle-cycle counter for the CREDIT state.
//   clk, rstn : clock, asynchronous active-low reset
//   clear     : forces the count back to 0 (wins over enable)
//   enable    : count one idle cycle
//   expired   : high in the TIMEOUT-th enabled cycle after a clear
module vend_timer #(
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // Count runs 0..TIMEOUT-1, so $clog2(TIMEOUT) bits suffice.
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expired = enable && !clear && (cnt_q == LAST);

endmodule

// File: rtl/vend_controller.sv
// vend_controller: coin-operated two-item vending controller.
//   clk, rstn : clock (rising edge), asynchronous active-low reset
//   bus       : vend_if.slave -- coin/select/cancel pulses and dispenser /
//               changer acknowledges in; dispense and change requests,
//               coin reject pulse, credit, busy and debug state out.
// Credit is counted in quarters. All outputs come straight from flops.
module vend_controller
    import vend_pkg::*;
#(
    parameter int PRICE_A    = 2,
    parameter int PRICE_B    = 3,
    parameter int CREDIT_MAX = 8,
    parameter int TIMEOUT    = 1000
) (
    input  logic  clk,
    input  logic  rstn,
    vend_if.slave bus
);

    localparam credit_t PRICE_A_C = credit_t'(PRICE_A);
    localparam credit_t PRICE_B_C = credit_t'(PRICE_B);

    logic [1:0] state_q, state_d;
    credit_t    credit_q, credit_d;
    logic       disp_item_q, disp_item_d;
    logic       disp_req_q, disp_req_d;
    logic       chg_req_q, chg_req_d;
    logic       coin_rej_q, coin_rej_d;
    logic       busy_q, busy_d;

    logic       cancel_go;
    logic       sel_valid;
    logic       sel_item;
    logic       coin_window;
    logic       d_acc, q_acc, coin_acc;
    credit_t    coin_val;
    credit_t    price_disp;
    logic       tmr_clear, tmr_en, tmr_expired;

    // Decisions taken in IDLE/CREDIT. Cancel beats select, select beats
    // coins; a coin only lands when the machine stays in IDLE/CREDIT.
    assign cancel_go   = (state_q == ST_CREDIT) && bus.cancel;
    // sel_a pressed means A is the request, whatever sel_b does.
    assign sel_valid   = (state_q == ST_CREDIT) &&
                         (bus.sel_a ? (credit_q >= PRICE_A_C)
                                    : (bus.sel_b && (credit_q >= PRICE_B_C)));
    assign sel_item    = bus.sel_a ? ITEM_A : ITEM_B;
    assign coin_window = ((state_q == ST_IDLE) || (state_q == ST_CREDIT)) &&
                         !cancel_go && !sel_valid;

    // Dollar is judged first; a quarter arriving with a dollar is returned.
    assign d_acc    = coin_window && bus.d_in &&
                      coin_fits(credit_q, DOLLAR, CREDIT_MAX);
    assign q_acc    = coin_window && bus.q_in && !bus.d_in &&
                      coin_fits(credit_q, QUARTER, CREDIT_MAX);
    assign coin_acc = d_acc || q_acc;
    assign coin_val = d_acc ? DOLLAR : QUARTER;

    assign coin_rej_d = (bus.d_in && !d_acc) || (bus.q_in && !q_acc);

    assign price_disp = (disp_item_q == ITEM_B) ? PRICE_B_C : PRICE_A_C;

    // Idle counting only in CREDIT; an accepted coin (including the one
    // that enters CREDIT from IDLE) restarts it.
    assign tmr_en    = (state_q == ST_CREDIT);
    assign tmr_clear = coin_acc || (state_q != ST_CREDIT);

    vend_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rstn    (rstn),
        .clear   (tmr_clear),
        .enable  (tmr_en),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d     = state_q;
        credit_d    = credit_q;
        disp_item_d = disp_item_q;
        case (state_q)
            ST_IDLE: begin
                if (coin_acc) begin
                    credit_d = credit_q + coin_val;
                    state_d  = ST_CREDIT;
                end
            end
            ST_CREDIT: begin
                if (cancel_go) begin
                    state_d = ST_CHANGE;
                end else if (sel_valid) begin
                    state_d     = ST_DISPENSE;
                    disp_item_d = sel_item;
                end else if (coin_acc) begin
                    credit_d = credit_q + coin_val;
                end else if (tmr_expired) begin
                    state_d = ST_CHANGE;
                end
            end
            ST_DISPENSE: begin
                if (bus.disp_ack && disp_req_q) begin
                    // Saturating subtract keeps credit from wrapping.
                    if (credit_q > price_disp) begin
                        credit_d = credit_q - price_disp;
                        state_d  = ST_CHANGE;
                    end else begin
                        credit_d = '0;
                        state_d  = ST_IDLE;
                    end
                end
            end
            ST_CHANGE: begin
                if (credit_q == '0) begin
                    state_d = ST_IDLE;
                end else if (bus.chg_ack && chg_req_q) begin
                    credit_d = credit_q - QUARTER;
                    if (credit_q == QUARTER) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request levels follow the next state so they change with it.
    assign disp_req_d = (state_d == ST_DISPENSE);
    assign chg_req_d  = (state_d == ST_CHANGE);
    assign busy_d     = (state_d == ST_DISPENSE) || (state_d == ST_CHANGE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            credit_q    <= '0;
            disp_item_q <= 1'b0;
            disp_req_q  <= 1'b0;
            chg_req_q   <= 1'b0;
            coin_rej_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            credit_q    <= credit_d;
            disp_item_q <= disp_item_d;
            disp_req_q  <= disp_req_d;
            chg_req_q   <= chg_req_d;
            coin_rej_q  <= coin_rej_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.state     = state_q;
    assign bus.credit    = credit_q;
    assign bus.disp_item = disp_item_q;
    assign bus.disp_req  = disp_req_q;
    assign bus.chg_req   = chg_req_q;
    assign bus.coin_rej  = coin_rej_q;
    assign bus.busy      = busy_q;

endmodule

// File: doc/vend_controller.md
VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 Parameter PRICE_A, default 2, item A price in quarters.
REQ-002 Parameter PRICE_B, default 3, item B price in quarters.
REQ-003 Parameter CREDIT_MAX, default 8, credit ceiling in quarters; legal range 4..15.
REQ-004 Parameter TIMEOUT, default 1000, idle cycles in CREDIT before auto-refund; minimum 2.
REQ-005 clk  in  1  clock, rising edge.
REQ-006 rstn  in  1  reset, asynchronous, active-low.
REQ-007 q_in  in  1  quarter inserted, one-cycle pulse, value 1 quarter.
REQ-008 d_in  in  1  dollar inserted, one-cycle pulse, value 4 quarters.
REQ-009 sel_a, sel_b  in  1 each  item-select pulses.
REQ-010 cancel  in  1  refund request pulse.
REQ-011 disp_ack  in  1  dispenser done; valid only while disp_req=1.
REQ-012 chg_ack  in  1  one quarter ejected; valid only while chg_req=1.
REQ-013 disp_req  out  1  dispense request, level.
REQ-014 disp_item  out  1  item being dispensed: 0=A, 1=B; stable while disp_req=1.
REQ-015 chg_req  out  1  eject-one-quarter request, level.
REQ-016 coin_rej  out  1  one-cycle pulse: coin returned, not credited.
REQ-017 credit  out  4  current credit in quarters.
REQ-018 busy  out  1  high in DISPENSE or CHANGE.

Function
REQ-019 FSM states SHALL be IDLE, CREDIT, DISPENSE, CHANGE; all outputs registered.
REQ-020 IDLE/CREDIT: accepted coin adds its value to credit next cycle; IDLE -> CREDIT on first accepted coin.
REQ-021 Coin that would make credit exceed CREDIT_MAX SHALL NOT be credited; coin_rej pulses the next cycle.
REQ-022 q_in and d_in in the same cycle: d_in evaluated first; q_in always rejected.
REQ-023 Coins in DISPENSE or CHANGE SHALL be rejected with coin_rej.
REQ-024 In CREDIT, a select with credit >= its price -> DISPENSE next cycle; disp_req=1 and disp_item set that cycle.
REQ-025 A select with insufficient credit SHALL be ignored, with no state or credit change.
REQ-026 sel_a and sel_b together: A wins.
REQ-027 Coin and valid select in the same cycle: select wins; coin rejected.
REQ-028 DISPENSE: disp_req held until disp_ack; on the ack cycle, credit -= price and disp_req drops next cycle.
REQ-029 After DISPENSE: -> CHANGE if remaining credit > 0, else -> IDLE.
REQ-030 CHANGE: chg_req=1; each chg_ack decrements credit by 1; -> IDLE with chg_req=0 the cycle after credit reaches 0.
REQ-031 Cancel in CREDIT -> CHANGE; cancel in IDLE, DISPENSE or CHANGE is ignored.
REQ-032 Cancel with a valid select in the same cycle: cancel wins.
REQ-033 Timeout counter runs in CREDIT and clears on any accepted coin or on entering CREDIT.
REQ-034 On reaching TIMEOUT, CREDIT -> CHANGE.
REQ-035 Credit SHALL never underflow or exceed CREDIT_MAX.

Reset
REQ-036 rstn=0 forces, asynchronously: state IDLE, credit 0, timeout counter 0, and disp_req, disp_item, chg_req, coin_rej, busy all 0.
REQ-037 Reset mid-DISPENSE or mid-CHANGE abandons the transaction; no refund is owed after reset.

Structure
REQ-038 Package vend_pkg SHALL hold the state encoding, the coin values (QUARTER=1, DOLLAR=4) and the credit width.
REQ-039 Timeout counter SHALL be sub-module vend_timer, with inputs clear, enable and outputs expired.

Verification
REQ-040 Bench SHALL cover q,q then sel_a -> disp_req=1, disp_item=0; after disp_ack: credit 0, IDLE, no chg_req.
REQ-041 Bench SHALL cover d then sel_b -> dispense B; after ack: credit 1, chg_req=1; one chg_ack -> credit 0, IDLE.
REQ-042 Bench SHALL cover d,d (credit 8) then q -> coin_rej pulse, credit stays 8; sel_a and sel_b together -> item A.
REQ-043 Bench SHALL cover q then sel_b -> ignored, credit 1, state CREDIT; then cancel -> 1 chg_req handshake, IDLE.
REQ-044 Bench SHALL cover q, then TIMEOUT idle cycles -> CHANGE, one quarter refunded; q_in during CHANGE -> coin_rej.
REQ-045 Bench SHALL cover rstn asserted while disp_req=1 -> all outputs 0 immediately, credit 0, IDLE after release.
